// File: rtl/aes_dec_key_sched.sv
// AES-128 round-key store: expands a cipher key into 11 round keys, one per clock,
// then serves them one per request (10->0 for decryption, 0->10 when REVERSE=0).
module aes_dec_key_sched #(
  parameter bit REVERSE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  input  logic         rk_next,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic [127:0] rk_out,
  output logic         busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  localparam logic [3:0] START_IDX = REVERSE ? 4'd10 : 4'd0;
  localparam logic [3:0] TERM_IDX  = REVERSE ? 4'd0  : 4'd10;

  logic [1:0]   state;
  logic [3:0]   cnt;
  logic [3:0]   prev_idx;
  logic [127:0] rk [0:10];
  logic [127:0] next_rk;
  logic         load;

  // Forward S-box: upper nibble picks a row, lower nibble picks the byte in it.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [127:0] row;
    case (b[7:4])
      4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
      4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
      4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
      4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
      4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
      4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
      4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
      4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
      4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
      4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
      4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
      4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
      4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
      4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
      4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
      default: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
    endcase
    return row[{~b[3:0], 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
         ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign key_ready = (state == IDLE) || (state == READY);
  assign busy      = (state == EXPAND);
  assign rk_valid  = (state == READY);
  assign load      = key_valid && key_ready;
  assign prev_idx  = cnt - 4'd1;
  assign next_rk   = expand(rk[prev_idx], rcon(cnt));
  assign rk_out    = rk_valid ? rk[rk_idx] : 128'h0;

  // A load always wins over rk_next, so a new key can replace the old one mid-walk.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      rk_idx <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state <= EXPAND;
            cnt   <= 4'd1;
          end
        end
        EXPAND: begin
          if (cnt == 4'd10) begin
            state  <= READY;
            cnt    <= 4'd0;
            rk_idx <= START_IDX;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        READY: begin
          if (load) begin
            state <= EXPAND;
            cnt   <= 4'd1;
          end else if (rk_next) begin
            if (rk_idx == TERM_IDX)
              rk_idx <= START_IDX;
            else if (REVERSE)
              rk_idx <= rk_idx - 4'd1;
            else
              rk_idx <= rk_idx + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register file is deliberately left unreset; reset only stops further writes.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (load)
        rk[0] <= key_in;
      else if (state == EXPAND)
        rk[cnt] <= next_rk;
    end
  end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Self-checking bench for aes_dec_key_sched: decrypt-order instance plus an
// encrypt-order instance, with expected round keys taken from FIPS-197 vectors.
module tb_aes_dec_key_sched;

  logic         clk = 1'b0;
  logic         rst_n, key_valid, rk_next, key_valid1, rk_next1;
  logic [127:0] key_in;
  logic         key_ready, rk_valid, busy, key_ready1, rk_valid1, busy1;
  logic [3:0]   rk_idx, rk_idx1;
  logic [127:0] rk_out, rk_out1;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] rk;
  } exp_t;

  exp_t         sb[$];
  exp_t         e;
  logic [127:0] tab [0:10];
  int           checks = 0;
  int           errors = 0;
  int           n;

  always #5 clk = ~clk;

  aes_dec_key_sched #(.REVERSE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_in(key_in), .rk_next(rk_next), .rk_valid(rk_valid), .rk_idx(rk_idx),
    .rk_out(rk_out), .busy(busy)
  );

  aes_dec_key_sched #(.REVERSE(1'b0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid1), .key_ready(key_ready1),
    .key_in(key_in), .rk_next(rk_next1), .rk_valid(rk_valid1), .rk_idx(rk_idx1),
    .rk_out(rk_out1), .busy(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_valid = 1'b0; rk_next = 1'b0;
    key_valid1 = 1'b0; rk_next1 = 1'b0; key_in = '0;
    tick(); tick();
    checks++;
    if ({key_ready, rk_valid, busy, rk_idx} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("[TB] FAIL reset_flags got rdy/val/busy/idx=%b%b%b/%0d want 100/0",
               key_ready, rk_valid, busy, rk_idx);
    end
    checks++;
    if (rk_out !== 128'h0) begin
      errors++;
      $display("[TB] FAIL reset_rk_out got %h want 0", rk_out);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_latency();
    key_in = 128'h000102030405060708090a0b0c0d0e0f;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    checks++;
    if ({key_ready, rk_valid, busy} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL expand_flags got rdy/val/busy=%b%b%b want 001", key_ready, rk_valid, busy);
    end
    sb.push_back('{idx: 4'd10, rk: 128'h13111d7fe3944a17f307a78b4d2b30c5});
    n = 1;
    tick();
    while (!rk_valid && n < 20) begin tick(); n++; end
    checks++;
    if (n !== 10) begin
      errors++;
      $display("[TB] FAIL load_latency got %0d cycles want 10", n);
    end
    e = sb.pop_front();
    checks++;
    if ({rk_valid, busy, key_ready, rk_idx, rk_out} !== {3'b101, e.idx, e.rk}) begin
      errors++;
      $display("[TB] FAIL first_rk got val=%b busy=%b idx=%0d rk=%h want 1 0 %0d %h",
               rk_valid, busy, rk_idx, rk_out, e.idx, e.rk);
    end
  endtask

  task automatic test_reverse_walk();
    key_in = tab[0];
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    sb.push_back('{idx: 4'd10, rk: tab[10]});
    n = 1;
    tick();
    while (!rk_valid && n < 20) begin tick(); n++; end
    for (int i = 10; i >= 0; i--) begin
      e = sb.pop_front();
      checks++;
      if ({rk_valid, rk_idx, rk_out} !== {1'b1, e.idx, e.rk}) begin
        errors++;
        $display("[TB] FAIL rev_walk got val=%b idx=%0d rk=%h want 1 %0d %h",
                 rk_valid, rk_idx, rk_out, e.idx, e.rk);
      end
      if (i > 0) begin
        sb.push_back('{idx: 4'(i - 1), rk: tab[i - 1]});
        rk_next = 1'b1;
        tick();
        rk_next = 1'b0;
      end
    end
  endtask

  task automatic test_wrap();
    sb.push_back('{idx: 4'd10, rk: tab[10]});
    rk_next = 1'b1;
    tick();
    rk_next = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({rk_valid, rk_idx, rk_out} !== {1'b1, e.idx, e.rk}) begin
      errors++;
      $display("[TB] FAIL rev_wrap got val=%b idx=%0d rk=%h want 1 %0d %h",
               rk_valid, rk_idx, rk_out, e.idx, e.rk);
    end
  endtask

  task automatic test_load_priority();
    key_in = 128'h0;
    key_valid = 1'b1;
    rk_next = 1'b1;
    tick();
    key_valid = 1'b0;
    rk_next = 1'b0;
    checks++;
    if ({rk_valid, busy, rk_idx} !== {1'b0, 1'b1, 4'd10}) begin
      errors++;
      $display("[TB] FAIL load_priority got val=%b busy=%b idx=%0d want 0 1 10",
               rk_valid, busy, rk_idx);
    end
    sb.push_back('{idx: 4'd10, rk: 128'hb4ef5bcb3e92e21123e951cf6f8f188e});
    n = 1;
    tick();
    while (!rk_valid && n < 20) begin tick(); n++; end
    e = sb.pop_front();
    checks++;
    if ({n[3:0], rk_idx, rk_out} !== {4'd10, e.idx, e.rk}) begin
      errors++;
      $display("[TB] FAIL zero_key got cycles=%0d idx=%0d rk=%h want 10 %0d %h",
               n, rk_idx, rk_out, e.idx, e.rk);
    end
  endtask

  task automatic test_reset_abort();
    key_in = tab[0];
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({key_ready, rk_valid, busy, rk_idx} !== {1'b1, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("[TB] FAIL abort_flags got rdy/val/busy/idx=%b%b%b/%0d want 100/0",
               key_ready, rk_valid, busy, rk_idx);
    end
    for (int i = 0; i < 3; i++) begin
      rk_next = 1'b1;
      tick();
      rk_next = 1'b0;
      checks++;
      if ({rk_valid, busy, rk_idx, rk_out} !== {1'b0, 1'b0, 4'd0, 128'h0}) begin
        errors++;
        $display("[TB] FAIL idle_rk_next got val=%b busy=%b idx=%0d rk=%h want 0 0 0 0",
                 rk_valid, busy, rk_idx, rk_out);
      end
    end
    key_in = 128'h000102030405060708090a0b0c0d0e0f;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    sb.push_back('{idx: 4'd10, rk: 128'h13111d7fe3944a17f307a78b4d2b30c5});
    n = 1;
    tick();
    while (!rk_valid && n < 20) begin tick(); n++; end
    e = sb.pop_front();
    checks++;
    if ({n[3:0], rk_idx, rk_out} !== {4'd10, e.idx, e.rk}) begin
      errors++;
      $display("[TB] FAIL reload got cycles=%0d idx=%0d rk=%h want 10 %0d %h",
               n, rk_idx, rk_out, e.idx, e.rk);
    end
  endtask

  task automatic test_forward_walk();
    key_in = tab[0];
    key_valid1 = 1'b1;
    tick();
    key_valid1 = 1'b0;
    sb.push_back('{idx: 4'd0, rk: tab[0]});
    n = 1;
    tick();
    while (!rk_valid1 && n < 20) begin tick(); n++; end
    for (int i = 0; i <= 11; i++) begin
      e = sb.pop_front();
      checks++;
      if ({rk_valid1, rk_idx1, rk_out1} !== {1'b1, e.idx, e.rk}) begin
        errors++;
        $display("[TB] FAIL fwd_walk got val=%b idx=%0d rk=%h want 1 %0d %h",
                 rk_valid1, rk_idx1, rk_out1, e.idx, e.rk);
      end
      if (i < 11) begin
        sb.push_back('{idx: 4'((i + 1) % 11), rk: tab[(i + 1) % 11]});
        rk_next1 = 1'b1;
        tick();
        rk_next1 = 1'b0;
      end
    end
  endtask

  initial begin
    tab[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    tab[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    tab[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    tab[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    tab[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    tab[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    tab[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    tab[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    tab[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    tab[9]  = 128'hac7766f319fadc2128d12941575c006e;
    tab[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    test_reset();
    test_load_latency();
    test_reverse_walk();
    test_wrap();
    test_load_priority();
    test_reset_abort();
    test_forward_walk();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout after %0d checks", checks);
    $fatal(1, "[TB] watchdog");
  end

endmodule
